// File: rtl/net_msg_pkg.sv
// Shared definitions for the messenger/network endpoint:
// header kinds, FSM state codes, flit counts and the NETPARAM layout.
package net_msg_pkg;

    localparam logic [1:0] KIND_CALL = 2'b00;
    localparam logic [1:0] KIND_STAT = 2'b01;
    localparam logic [1:0] KIND_REQ  = 2'b10;

    localparam int CALL_FLITS = 4;
    localparam int STAT_FLITS = 2;

    typedef logic [2:0] tx_state_t;
    localparam tx_state_t TX_IDLE = 3'd0;
    localparam tx_state_t TX_HDR  = 3'd1;
    localparam tx_state_t TX_B0   = 3'd2;
    localparam tx_state_t TX_B1   = 3'd3;
    localparam tx_state_t TX_B2   = 3'd4;
    localparam tx_state_t TX_DONE = 3'd5;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_HDR  = 3'd0;
    localparam rx_state_t RX_P0   = 3'd1;
    localparam rx_state_t RX_P1   = 3'd2;
    localparam rx_state_t RX_P2   = 3'd3;
    localparam rx_state_t RX_P3   = 3'd4;
    localparam rx_state_t RX_SKIP = 3'd5;

    typedef struct packed {
        logic [1:0]  cpl;
        logic [23:0] target_pso;
        logic [15:0] task_id;
        logic [15:0] proc_indx;
        logic [31:0] param;
        logic [31:0] source_pso;
    } netparam_t;

    // Index of the final flit of an outgoing frame (header is index 0).
    function automatic logic [2:0] tx_last_idx(input logic is_stat);
        return is_stat ? 3'(STAT_FLITS - 1) : 3'(CALL_FLITS - 1);
    endfunction

endpackage

// File: rtl/net_msg_fifo.sv
// Synchronous FIFO for assembled incoming request words.
// Ports: CLK, RESETn, push/wdata, pop/rdata (head), full, empty, count.
module net_msg_fifo
    import net_msg_pkg::*;
#(
    parameter int WIDTH = $bits(netparam_t),
    parameter int DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A same-cycle pop frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/net_msg_endpoint.sv
// Network-side message endpoint: serialises outgoing call/status messages
// into 32-bit TX flits and assembles RX request frames into a FIFO.
// Ports: CLK/RESETn; NETSEND/NETTYPE/NETMSG/NETSTAT -> NETRDY, TXOVF;
//        NETREQ/NETPARAM <- NETMSGRD; TX and RX flit channels; RXERR.
module net_msg_endpoint
    import net_msg_pkg::*;
#(
    parameter int RXDEPTH = 2
) (
    input  logic         CLK,
    input  logic         RESETn,
    input  logic         NETSEND,
    input  logic         NETTYPE,
    input  logic [79:0]  NETMSG,
    input  logic [4:0]   NETSTAT,
    output logic         NETRDY,
    output logic         NETREQ,
    output logic [121:0] NETPARAM,
    input  logic         NETMSGRD,
    output logic         TXVALID,
    input  logic         TXREADY,
    output logic [31:0]  TXDATA,
    output logic         TXLAST,
    input  logic         RXVALID,
    output logic         RXREADY,
    input  logic [31:0]  RXDATA,
    input  logic         RXLAST,
    output logic         TXOVF,
    output logic         RXERR
);

    localparam int CW = $clog2(RXDEPTH + 1);

    // ---------------- TX path ----------------
    tx_state_t   tx_st;
    logic [79:0] h_msg;
    logic        h_type;
    logic [4:0]  h_stat;
    logic        txovf_q;
    logic [1:0]  tx_idx;
    logic        tx_hs;

    always_comb begin
        TXVALID = 1'b0;
        TXDATA  = '0;
        tx_idx  = 2'd0;
        case (tx_st)
            TX_HDR: begin
                TXVALID = 1'b1;
                tx_idx  = 2'd0;
                TXDATA  = h_type ? {KIND_STAT, 25'd0, h_stat}
                                 : {KIND_CALL, 30'd0};
            end
            TX_B0: begin
                TXVALID = 1'b1;
                tx_idx  = 2'd1;
                TXDATA  = h_msg[31:0];
            end
            TX_B1: begin
                TXVALID = 1'b1;
                tx_idx  = 2'd2;
                TXDATA  = h_msg[63:32];
            end
            TX_B2: begin
                TXVALID = 1'b1;
                tx_idx  = 2'd3;
                TXDATA  = {16'd0, h_msg[79:64]};
            end
            default: ;
        endcase
    end

    assign TXLAST = TXVALID && ({1'b0, tx_idx} == tx_last_idx(h_type));
    assign tx_hs  = TXVALID && TXREADY;
    assign NETRDY = (tx_st == TX_DONE);
    assign TXOVF  = txovf_q;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            tx_st   <= TX_IDLE;
            h_msg   <= '0;
            h_type  <= 1'b0;
            h_stat  <= '0;
            txovf_q <= 1'b0;
        end else begin
            txovf_q <= NETSEND && (tx_st != TX_IDLE);
            case (tx_st)
                TX_IDLE: begin
                    if (NETSEND) begin
                        h_msg  <= NETMSG;
                        h_type <= NETTYPE;
                        h_stat <= NETSTAT;
                        tx_st  <= TX_HDR;
                    end
                end
                TX_HDR, TX_B0, TX_B1, TX_B2: begin
                    if (tx_hs) begin
                        tx_st <= TXLAST ? TX_DONE : tx_st + 3'd1;
                    end
                end
                default: tx_st <= TX_IDLE;
            endcase
        end
    end

    // ---------------- RX path ----------------
    rx_state_t   rx_st;
    logic [1:0]  r_cpl;
    logic [31:0] r_src;
    logic [31:0] r_prm;
    logic [15:0] r_tid;
    logic [15:0] r_pidx;
    logic        rxerr_q;
    logic        rx_en;
    logic        rx_hs;
    logic        push;
    logic        f_full;
    logic        f_empty;
    logic        full_eff;
    logic [CW-1:0] f_count;
    netparam_t   push_word;

    // Holds RXREADY low while in reset so every output reads 0.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) rx_en <= 1'b0;
        else         rx_en <= 1'b1;
    end

    assign full_eff = f_full && !(NETMSGRD && !f_empty);
    assign RXREADY  = rx_en && !((rx_st == RX_P3) && full_eff);
    assign rx_hs    = RXVALID && RXREADY;
    assign push     = rx_hs && (rx_st == RX_P3) && RXLAST;
    assign RXERR    = rxerr_q;
    assign NETREQ   = (f_count != '0);

    always_comb begin
        push_word            = '0;
        push_word.cpl        = r_cpl;
        push_word.target_pso = RXDATA[23:0];
        push_word.task_id    = r_tid;
        push_word.proc_indx  = r_pidx;
        push_word.param      = r_prm;
        push_word.source_pso = r_src;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rx_st   <= RX_HDR;
            r_cpl   <= '0;
            r_src   <= '0;
            r_prm   <= '0;
            r_tid   <= '0;
            r_pidx  <= '0;
            rxerr_q <= 1'b0;
        end else begin
            rxerr_q <= 1'b0;
            if (rx_hs) begin
                case (rx_st)
                    RX_HDR: begin
                        if (RXDATA[31:30] == KIND_REQ) begin
                            r_cpl <= RXDATA[25:24];
                            if (RXLAST) rxerr_q <= 1'b1;
                            rx_st <= RXLAST ? RX_HDR : RX_P0;
                        end else begin
                            rxerr_q <= 1'b1;
                            rx_st   <= RXLAST ? RX_HDR : RX_SKIP;
                        end
                    end
                    RX_P0: begin
                        r_src <= RXDATA;
                        if (RXLAST) rxerr_q <= 1'b1;
                        rx_st <= RXLAST ? RX_HDR : RX_P1;
                    end
                    RX_P1: begin
                        r_prm <= RXDATA;
                        if (RXLAST) rxerr_q <= 1'b1;
                        rx_st <= RXLAST ? RX_HDR : RX_P2;
                    end
                    RX_P2: begin
                        r_tid  <= RXDATA[31:16];
                        r_pidx <= RXDATA[15:0];
                        if (RXLAST) rxerr_q <= 1'b1;
                        rx_st  <= RXLAST ? RX_HDR : RX_P3;
                    end
                    RX_P3: begin
                        if (!RXLAST) rxerr_q <= 1'b1;
                        rx_st <= RXLAST ? RX_HDR : RX_SKIP;
                    end
                    RX_SKIP: begin
                        if (RXLAST) rx_st <= RX_HDR;
                    end
                    default: rx_st <= RX_HDR;
                endcase
            end
        end
    end

    net_msg_fifo #(
        .WIDTH ($bits(netparam_t)),
        .DEPTH (RXDEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RESETn (RESETn),
        .push   (push),
        .wdata  (push_word),
        .pop    (NETMSGRD),
        .rdata  (NETPARAM),
        .full   (f_full),
        .empty  (f_empty),
        .count  (f_count)
    );

endmodule

// File: tb/tb_net_msg_endpoint.sv
// Directed scoreboard bench for net_msg_endpoint: TX frames, RX assembly,
// FIFO full/pop interplay, malformed frames and async reset mid-frame.
module tb_net_msg_endpoint;

    logic         CLK = 1'b0;
    logic         RESETn = 1'b0;
    logic         NETSEND = 1'b0;
    logic         NETTYPE = 1'b0;
    logic [79:0]  NETMSG = '0;
    logic [4:0]   NETSTAT = '0;
    logic         NETRDY;
    logic         NETREQ;
    logic [121:0] NETPARAM;
    logic         NETMSGRD = 1'b0;
    logic         TXVALID;
    logic         TXREADY = 1'b0;
    logic [31:0]  TXDATA;
    logic         TXLAST;
    logic         RXVALID = 1'b0;
    logic         RXREADY;
    logic [31:0]  RXDATA = '0;
    logic         RXLAST = 1'b0;
    logic         TXOVF;
    logic         RXERR;

    net_msg_endpoint #(.RXDEPTH(2)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .NETSEND(NETSEND), .NETTYPE(NETTYPE),
        .NETMSG(NETMSG), .NETSTAT(NETSTAT),
        .NETRDY(NETRDY), .NETREQ(NETREQ),
        .NETPARAM(NETPARAM), .NETMSGRD(NETMSGRD),
        .TXVALID(TXVALID), .TXREADY(TXREADY),
        .TXDATA(TXDATA), .TXLAST(TXLAST),
        .RXVALID(RXVALID), .RXREADY(RXREADY),
        .RXDATA(RXDATA), .RXLAST(RXLAST),
        .TXOVF(TXOVF), .RXERR(RXERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_cnt = 0;
    logic [32:0]  txq [$];
    logic [121:0] rxq [$];

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // TX scoreboard: flits are compared in the cycle they are accepted.
    always @(negedge CLK) begin
        if (RESETn) begin
            if (NETRDY) rdy_cnt++;
            if (TXVALID && TXREADY) begin
                n_cmp++;
                assert (txq.size() != 0) else begin
                    n_bad++;
                    $error("FAIL tx_unexpected: observed %0h expected none",
                           TXDATA);
                end
                if (txq.size() != 0) begin
                    logic [32:0] e;
                    e = txq.pop_front();
                    chk("tx_flit", {TXDATA, TXLAST}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic tx_send(input logic t, input logic [79:0] m,
                           input logic [4:0] s, input bit expect_frame);
        if (expect_frame) begin
            if (!t) begin
                txq.push_back({32'h0, 1'b0});
                txq.push_back({m[31:0], 1'b0});
                txq.push_back({m[63:32], 1'b0});
                txq.push_back({16'h0, m[79:64], 1'b1});
            end else begin
                txq.push_back({2'b01, 25'd0, s, 1'b0});
                txq.push_back({m[31:0], 1'b1});
            end
        end
        NETSEND = 1'b1;
        NETTYPE = t;
        NETMSG  = m;
        NETSTAT = s;
        tick();
        NETSEND = 1'b0;
    endtask

    task automatic wait_rdy(input int exp_cyc, input string tag);
        int n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (NETRDY) begin
                n = i;
                break;
            end
        end
        chk({tag, "_rdy_latency"}, n, exp_cyc);
        tick();
        chk({tag, "_rdy_width"}, NETRDY, 1'b0);
    endtask

    task automatic rx_send(input logic [31:0] d, input logic l);
        bit ok = 0;
        RXVALID = 1'b1;
        RXDATA  = d;
        RXLAST  = l;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (RXREADY) begin
                ok = 1;
                break;
            end
        end
        tick();
        RXVALID = 1'b0;
        RXLAST  = 1'b0;
        chk("rx_accept", ok, 1'b1);
    endtask

    task automatic rx_frame(input logic [1:0] cpl, input logic [31:0] src,
                            input logic [31:0] prm, input logic [15:0] tid,
                            input logic [15:0] pidx, input logic [23:0] tgt);
        rxq.push_back({cpl, tgt, tid, pidx, prm, src});
        rx_send({2'b10, 4'd0, cpl, 24'd0}, 1'b0);
        rx_send(src, 1'b0);
        rx_send(prm, 1'b0);
        rx_send({tid, pidx}, 1'b0);
        rx_send({8'd0, tgt}, 1'b1);
    endtask

    task automatic rx_pop(input string tag);
        logic [121:0] e = 'x;
        if (rxq.size() != 0) e = rxq.pop_front();
        chk({tag, "_netreq"}, NETREQ, 1'b1);
        chk({tag, "_netparam"}, NETPARAM, e);
        NETMSGRD = 1'b1;
        tick();
        NETMSGRD = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_before;
        logic [121:0] e;
        // Reset state
        #2;
        chk("rst_txvalid", TXVALID, 1'b0);
        chk("rst_txdata", TXDATA, 32'h0);
        chk("rst_netrdy", NETRDY, 1'b0);
        chk("rst_netreq", NETREQ, 1'b0);
        chk("rst_netparam", NETPARAM, 122'h0);
        chk("rst_rxready", RXREADY, 1'b0);
        chk("rst_ovf_err", {TXOVF, RXERR, TXLAST}, 3'b000);
        tick();
        tick();
        RESETn = 1'b1;
        tick();
        chk("post_rst_rxready", RXREADY, 1'b1);

        // Call send, link always ready
        TXREADY = 1'b1;
        tx_send(1'b0, 80'h1234_89ABCDEF_01234567, 5'h0, 1);
        chk("call_txvalid", TXVALID, 1'b1);
        wait_rdy(4, "call");
        chk("call_rdy_cnt", rdy_cnt, 1);

        // Status send with a 3-cycle stall and an overflow attempt
        TXREADY = 1'b0;
        tx_send(1'b1, {48'h0, 32'hCAFEF00D}, 5'h15, 1);
        chk("stat_hdr", {TXVALID, TXDATA}, {1'b1, 32'h40000015});
        tick();
        chk("stat_hold1", TXDATA, 32'h40000015);
        tx_send(1'b0, 80'hFFFF_DEADBEEF_DEADBEEF, 5'h1F, 0);
        chk("txovf_pulse", TXOVF, 1'b1);
        tick();
        chk("txovf_clear", TXOVF, 1'b0);
        chk("stat_hold3", {TXVALID, TXDATA}, {1'b1, 32'h40000015});
        TXREADY = 1'b1;
        wait_rdy(2, "stat");
        chk("stat_rdy_cnt", rdy_cnt, 2);

        // Single RX frame
        rx_frame(2'd2, 32'h11111111, 32'h22222222, 16'd5, 16'd7,
                 24'hABCDEF);
        chk("rx1_netreq", NETREQ, 1'b1);
        chk("rx1_cpl", NETPARAM[121:120], 2'd2);
        chk("rx1_tgt", NETPARAM[119:96], 24'hABCDEF);
        chk("rx1_tid_pidx", NETPARAM[95:64], 32'h00050007);
        rx_pop("rx1");
        chk("rx1_empty", NETREQ, 1'b0);
        NETMSGRD = 1'b1;
        tick();
        NETMSGRD = 1'b0;
        chk("pop_empty_ignored", NETREQ, 1'b0);

        // FIFO full: third frame waits at P3 until a same-cycle pop
        rx_frame(2'd1, 32'hA0A0A0A0, 32'hA1A1A1A1, 16'hA2, 16'hA3,
                 24'hAAAAAA);
        rx_frame(2'd3, 32'hB0B0B0B0, 32'hB1B1B1B1, 16'hB2, 16'hB3,
                 24'hBBBBBB);
        rxq.push_back({2'd0, 24'hCCCCCC, 16'hC2, 16'hC3,
                       32'hC1C1C1C1, 32'hC0C0C0C0});
        rx_send({2'b10, 30'd0}, 1'b0);
        rx_send(32'hC0C0C0C0, 1'b0);
        rx_send(32'hC1C1C1C1, 1'b0);
        rx_send({16'hC2, 16'hC3}, 1'b0);
        RXVALID = 1'b1;
        RXDATA  = {8'd0, 24'hCCCCCC};
        RXLAST  = 1'b1;
        @(negedge CLK);
        chk("full_stall1", RXREADY, 1'b0);
        tick();
        @(negedge CLK);
        chk("full_stall2", RXREADY, 1'b0);
        NETMSGRD = 1'b1;
        #1;
        chk("full_pop_ready", RXREADY, 1'b1);
        e = rxq.pop_front();
        chk("full_head_a", NETPARAM, e);
        tick();
        NETMSGRD = 1'b0;
        RXVALID  = 1'b0;
        RXLAST   = 1'b0;
        rx_pop("full_b");
        chk("full_count2", NETREQ, 1'b1);
        rx_pop("full_c");
        chk("full_drained", NETREQ, 1'b0);

        // Malformed: early RXLAST on P1
        rx_send({2'b10, 30'd0}, 1'b0);
        rx_send(32'h1, 1'b0);
        rx_send(32'h2, 1'b1);
        chk("early_last_err", RXERR, 1'b1);
        tick();
        chk("early_last_clr", {RXERR, NETREQ}, 2'b00);

        // Malformed: bad header kind, skipped to RXLAST
        rx_send(32'hC0000000, 1'b0);
        chk("bad_kind_err", RXERR, 1'b1);
        rx_send(32'h82000000, 1'b0);
        rx_send(32'h33333333, 1'b0);
        rx_send(32'h44444444, 1'b1);
        chk("skip_done", {RXERR, NETREQ}, 2'b00);
        rx_frame(2'd0, 32'h55555555, 32'h66666666, 16'h77, 16'h88,
                 24'h999999);
        rx_pop("after_err");

        // Async reset mid TX and mid RX frame
        TXREADY = 1'b0;
        tx_send(1'b0, 80'h0BAD_0BAD0BAD_0BAD0BAD, 5'h0, 1);
        rx_send({2'b10, 30'd0}, 1'b0);
        rx_send(32'h12345678, 1'b0);
        #2;
        RESETn = 1'b0;
        #1;
        chk("mid_rst_tx", {TXVALID, TXLAST, TXDATA}, 34'h0);
        chk("mid_rst_net", {NETRDY, NETREQ, TXOVF, RXERR}, 4'h0);
        chk("mid_rst_rxready", RXREADY, 1'b0);
        txq.delete();
        rdy_before = rdy_cnt;
        tick();
        tick();
        RESETn  = 1'b1;
        TXREADY = 1'b1;
        tick();
        chk("mid_rst_no_rdy", rdy_cnt, rdy_before);
        tx_send(1'b0, 80'hAAAA_55555555_AAAAAAAA, 5'h0, 1);
        wait_rdy(4, "post_rst_call");
        rx_frame(2'd1, 32'hDEAD0001, 32'hDEAD0002, 16'h3, 16'h4,
                 24'h123456);
        rx_pop("post_rst_rx");

        chk("txq_drained", txq.size(), 0);
        chk("rxq_drained", rxq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/net_msg_endpoint.md
Name: net_msg_endpoint

Overview:
Network-side endpoint of the messenger/network-controller message interface. It receives outgoing call and status messages from the messenger core (NETSEND/NETMSG/NETTYPE/NETSTAT), serialises them into 32-bit flits on the link TX channel, and confirms completion with a NETRDY pulse. It also assembles incoming request frames from the link RX channel into 122-bit NETPARAM words. These are buffered in a small FIFO and presented to the messenger as NETREQ, and each is released on NETMSGRD.

Parameters:
RXDEPTH, 2, incoming message FIFO depth; power of two, ≥2.

Ports:
CLK  in  1  clock; all logic on rising edge.
RESETn  in  1  asynchronous active-low reset.
NETSEND  in  1  one-cycle pulse: NETMSG/NETTYPE/NETSTAT valid, send message.
NETTYPE  in  1  0 = procedure call message, 1 = status report.
NETMSG  in  80  outgoing message body.
NETSTAT  in  5  status code (status report only).
NETRDY  out  1  one-cycle pulse: outgoing message fully transmitted.
NETREQ  out  1  level: FIFO head holds an incoming message.
NETPARAM  out  122  FIFO head: CPL[121:120], TargetPSO[119:96], TaskID[95:80], ProcINDX[79:64], Parameter[63:32], SourcePSO[31:0].
NETMSGRD  in  1  one-cycle pulse: head consumed, pop.
TXVALID  out  1  link TX flit valid.
TXREADY  in  1  link TX accept.
TXDATA  out  32  link TX flit.
TXLAST  out  1  final flit of frame.
RXVALID  in  1  link RX flit valid.
RXREADY  out  1  endpoint accepts RX flit.
RXDATA  in  32  link RX flit.
RXLAST  in  1  final flit of RX frame.
TXOVF  out  1  one-cycle pulse: NETSEND while TX busy, message dropped.
RXERR  out  1  one-cycle pulse: malformed RX frame discarded.

Behaviour:
- Reset (async, RESETn=0): all outputs 0; TX FSM=IDLE; RX FSM=HDR; FIFO empty; count=0.
- Flit handshake: transfer when VALID & READY on a rising edge; TXVALID/TXDATA/TXLAST held stable until accepted.
- TX FSM IDLE→HDR→B0→(B1→B2 for call)→DONE→IDLE.
  - NETSEND in IDLE latches NETMSG/NETTYPE/NETSTAT into a holding register; TXVALID rises the next cycle.
  - Call frame, 4 flits: H={2'b00,30'd0}, NETMSG[31:0], NETMSG[63:32], {16'd0,NETMSG[79:64]}+TXLAST.
  - Status frame, 2 flits: H={2'b01,25'd0,NETSTAT}, NETMSG[31:0]+TXLAST.
  - DONE: NETRDY=1 for exactly one cycle, the cycle after the last-flit handshake.
  - NETSEND outside IDLE: ignored, holding register untouched, TXOVF pulses the next cycle.
- RX FSM HDR→P0→P1→P2→P3→HDR, one state per accepted flit.
  - HDR valid only if RXDATA[31:30]==2'b10; latch CPL=RXDATA[25:24].
  - P0 = SourcePSO; P1 = Parameter; P2 = {TaskID[31:16],ProcINDX[15:0]}; P3 = {8'd0,TargetPSO[23:0]} with RXLAST=1.
  - P3 handshake pushes the assembled 122-bit word into the FIFO.
- RXREADY = 1 in all states except P3 with FIFO full. Full is evaluated after any same-cycle pop, so a pop frees the slot in the same cycle.
- RX error cases (each: RXERR pulse, nothing pushed):
  - Bad header kind: enter SKIP, accept flits until RXLAST, then HDR.
  - RXLAST on HDR/P0/P1/P2: return to HDR.
  - P3 without RXLAST: enter SKIP.
- FIFO:
  - NETREQ = count≠0; NETPARAM = head, stable until popped.
  - A pushed word is visible on NETREQ/NETPARAM the cycle after the P3 handshake.
  - NETMSGRD when empty: ignored.
  - Push and pop in the same cycle: both occur, count unchanged, pointers wrap mod RXDEPTH.
- TX and RX paths are fully independent; simultaneous activity is permitted.
- Reset mid-frame: frame lost, no NETRDY; link partners recover via their own reset.

Decomposition:
- Package net_msg_pkg:
  - Header kind constants: KIND_CALL=2'b00, KIND_STAT=2'b01, KIND_REQ=2'b10.
  - TX and RX state enums.
  - Packed struct for the 122-bit NETPARAM layout.
  - Flit count constants.
- One sub-module, net_msg_fifo: parameterised sync FIFO (width 122, depth RXDEPTH), async active-low reset, push/pop/full/empty/count.

Test Plan:
- Call send: NETSEND, NETTYPE=0, NETMSG=80'h1234_89ABCDEF_01234567, TXREADY=1 → flits 0x00000000, 0x01234567, 0x89ABCDEF, 0x00001234 (TXLAST); NETRDY pulses one cycle after the last flit.
- Status send with TXREADY stalled 3 cycles: NETSTAT=5'h15, NETMSG[31:0]=0xCAFEF00D → flits 0x40000015, 0xCAFEF00D; data held during stall; single NETRDY; a second NETSEND during the stall → TXOVF pulse, frame unchanged.
- RX frame: H=0x82000000, P0=0x11111111, P1=0x22222222, P2=0x00050007, P3=0x00ABCDEF+RXLAST → NETREQ=1 next cycle; NETPARAM: CPL=2, TargetPSO=0xABCDEF, TaskID=5, ProcINDX=7; NETMSGRD → NETREQ=0.
- FIFO full (RXDEPTH=2): three back-to-back frames, no NETMSGRD → RXREADY=0 at the third P3; NETMSGRD in that cycle → the third frame is accepted the same cycle, count stays 2, order preserved.
- Malformed: RXLAST on P1 → RXERR, no push; header 0xC0000000 followed by 3 flits ending in RXLAST → RXERR, all skipped; the next valid frame is accepted normally.
- Async reset asserted mid TX and mid RX frame → all outputs 0 immediately; after release, new frames work from HDR/IDLE.
